// File: rtl/ber_window_monitor_if.sv
// Symbol-comparator side of the BER window monitor. The master drives the
// per-symbol flags and the window boundary pulse. The slave (the monitor)
// returns running counts, latched totals, status flags and lock.
interface ber_window_monitor_if #(
   parameter int unsigned CNT_W = 24
);

   // Comparator / window control
   logic             sym_clk_ena;
   logic             clear_accumulator;
   logic             sym_correct;
   logic             sym_error;

   // Measurement results
   logic [CNT_W-1:0] symbol_count;
   logic [CNT_W-1:0] error_count;
   logic [CNT_W-1:0] symbols_latched;
   logic [CNT_W-1:0] errors_latched;
   logic             result_valid;
   logic             saturated;
   logic             illegal_flag;
   logic             locked;
   logic [1:0]       meas_state;

   modport master (
      output sym_clk_ena,
      output clear_accumulator,
      output sym_correct,
      output sym_error,
      input  symbol_count,
      input  error_count,
      input  symbols_latched,
      input  errors_latched,
      input  result_valid,
      input  saturated,
      input  illegal_flag,
      input  locked,
      input  meas_state
   );

   modport slave (
      input  sym_clk_ena,
      input  clear_accumulator,
      input  sym_correct,
      input  sym_error,
      output symbol_count,
      output error_count,
      output symbols_latched,
      output errors_latched,
      output result_valid,
      output saturated,
      output illegal_flag,
      output locked,
      output meas_state
   );

endinterface

// File: rtl/ber_window_monitor.sv
// Windowed bit/symbol error-rate monitor. It counts qualified symbols and
// errors between clear_accumulator pulses and latches each closed window's
// totals. Lock is declared after LOCK_WINDOWS consecutive good windows.
module ber_window_monitor #(
   parameter int unsigned CNT_W        = 24,
   parameter int unsigned LOCK_THRESH  = 100,
   parameter int unsigned LOCK_WINDOWS = 2
) (
   input  logic                sys_clk,
   input  logic                reset,
   ber_window_monitor_if.slave bus
);

   // The threshold comparison is done wide enough that a threshold above the
   // counter range is never truncated.
   localparam int unsigned       CMP_W    = (CNT_W > 32) ? CNT_W : 32;
   localparam logic [CMP_W-1:0]  THRESH   = CMP_W'(LOCK_THRESH);
   localparam int unsigned       GOOD_W   = (LOCK_WINDOWS < 1) ? 1 : $clog2(LOCK_WINDOWS + 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_WINDOWS);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCount = 2'd1
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;

   logic [CNT_W-1:0]  r_sym_cnt;
   logic [CNT_W-1:0]  r_err_cnt;
   logic [CNT_W-1:0]  r_sym_lat;
   logic [CNT_W-1:0]  r_err_lat;
   logic              r_valid;
   logic              r_sat;
   logic              r_ill;
   logic              r_locked;
   logic [GOOD_W-1:0] r_good_cnt;

   logic              w_counting;
   logic              w_qual;
   logic              w_err_hit;
   logic              w_ill_hit;
   logic              w_close;
   logic [CNT_W-1:0]  w_sym_inc;
   logic [CNT_W-1:0]  w_err_inc;
   logic              w_sat_win;
   logic              w_ill_win;
   logic              w_good;
   logic [GOOD_W-1:0] w_good_nxt;

   // Symbols only count once the first window boundary has been seen.
   assign w_counting = (r_state == StCount);
   assign w_qual     = w_counting & bus.sym_clk_ena & (bus.sym_correct | bus.sym_error);
   assign w_err_hit  = w_counting & bus.sym_clk_ena & bus.sym_error;
   assign w_ill_hit  = w_counting & bus.sym_clk_ena & bus.sym_correct & bus.sym_error;

   // Running totals including this cycle's symbol, saturating at all-ones.
   always_comb begin
      w_sym_inc = r_sym_cnt;
      w_err_inc = r_err_cnt;
      if (w_qual && !(&r_sym_cnt)) begin
         w_sym_inc = r_sym_cnt + CNT_W'(1);
      end
      if (w_err_hit && !(&r_err_cnt)) begin
         w_err_inc = r_err_cnt + CNT_W'(1);
      end
   end

   // Window status as it stands after this cycle; used both to update the
   // sticky flags and to grade the window when it closes on this cycle.
   always_comb begin
      w_sat_win = r_sat | (&w_sym_inc) | (&w_err_inc);
      w_ill_win = r_ill | w_ill_hit;
      w_good    = (CMP_W'(w_err_inc) <= THRESH) && !w_sat_win && !w_ill_win;
      if (!w_good) begin
         w_good_nxt = '0;
      end else if (r_good_cnt == GOOD_MAX) begin
         w_good_nxt = r_good_cnt;
      end else begin
         w_good_nxt = r_good_cnt + GOOD_W'(1);
      end
   end

   // Measurement FSM next state; the very first boundary only arms counting.
   always_comb begin
      w_state_nxt = r_state;
      w_close     = 1'b0;
      case (r_state)
         StIdle: begin
            if (bus.clear_accumulator) begin
               w_state_nxt = StCount;
            end
         end
         StCount: begin
            if (bus.clear_accumulator) begin
               w_close = 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Measurement FSM state register.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Counters, window latching and lock tracking.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_sym_cnt  <= '0;
         r_err_cnt  <= '0;
         r_sym_lat  <= '0;
         r_err_lat  <= '0;
         r_valid    <= 1'b0;
         r_sat      <= 1'b0;
         r_ill      <= 1'b0;
         r_locked   <= 1'b0;
         r_good_cnt <= '0;
      end else begin
         r_valid <= w_close;
         if (w_close) begin
            // The boundary-cycle symbol belongs to the window being closed.
            r_sym_lat  <= w_sym_inc;
            r_err_lat  <= w_err_inc;
            r_sym_cnt  <= '0;
            r_err_cnt  <= '0;
            r_sat      <= 1'b0;
            r_ill      <= 1'b0;
            r_good_cnt <= w_good_nxt;
            r_locked   <= (w_good_nxt == GOOD_MAX);
         end else if (w_counting) begin
            r_sym_cnt <= w_sym_inc;
            r_err_cnt <= w_err_inc;
            r_sat     <= w_sat_win;
            r_ill     <= w_ill_win;
         end
      end
   end

   assign bus.symbol_count    = r_sym_cnt;
   assign bus.error_count     = r_err_cnt;
   assign bus.symbols_latched = r_sym_lat;
   assign bus.errors_latched  = r_err_lat;
   assign bus.result_valid    = r_valid;
   assign bus.saturated       = r_sat;
   assign bus.illegal_flag    = r_ill;
   assign bus.locked          = r_locked;
   assign bus.meas_state      = r_state;

endmodule

// File: tb/tb_ber_window_monitor.sv
// Bench for ber_window_monitor: a qualification vector table, window-level
// sequences with a result scoreboard, and a narrow-counter saturation DUT.
module tb_ber_window_monitor;

   localparam int unsigned CNT_W  = 24;
   localparam int unsigned THRESH = 100;
   localparam int unsigned LOCK_N = 2;

   logic clk = 1'b0;
   logic rst;
   logic rst4;

   always #5 clk = ~clk;

   ber_window_monitor_if #(.CNT_W(CNT_W)) bus ();
   ber_window_monitor_if #(.CNT_W(4))     bus4 ();

   ber_window_monitor #(
      .CNT_W        (CNT_W),
      .LOCK_THRESH  (THRESH),
      .LOCK_WINDOWS (LOCK_N)
   ) dut (
      .sys_clk (clk),
      .reset   (rst),
      .bus     (bus)
   );

   ber_window_monitor #(
      .CNT_W        (4),
      .LOCK_THRESH  (THRESH),
      .LOCK_WINDOWS (LOCK_N)
   ) dut4 (
      .sys_clk (clk),
      .reset   (rst4),
      .bus     (bus4)
   );

   typedef struct {
      int sym;
      int err;
      bit lck;
   } res_t;

   typedef struct {
      bit ena;
      bit cor;
      bit err;
      int d_sym;
      int d_err;
      bit ill;
   } vec_t;

   res_t sb_q[$];
   vec_t vecs[9];

   int  n_checks = 0;
   int  n_pass   = 0;

   // Window-level reference state.
   bit  m_counting;
   int  m_sym;
   int  m_err;
   bit  m_ill;
   int  m_good;
   bit  m_locked;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle on the main DUT and advance the reference.
   task automatic step(input bit ena, input bit cor, input bit err, input bit clr);
      bit good;
      bus.sym_clk_ena       = ena;
      bus.sym_correct       = cor;
      bus.sym_error         = err;
      bus.clear_accumulator = clr;
      if (m_counting) begin
         if (ena && (cor || err)) m_sym++;
         if (ena && err) m_err++;
         if (ena && cor && err) m_ill = 1'b1;
         if (clr) begin
            good = (m_err <= THRESH) && !m_ill;
            m_good = good ? ((m_good < LOCK_N) ? m_good + 1 : m_good) : 0;
            m_locked = (m_good == LOCK_N);
            sb_q.push_back('{sym: m_sym, err: m_err, lck: m_locked});
            m_sym = 0;
            m_err = 0;
            m_ill = 1'b0;
         end
      end else if (clr) begin
         m_counting = 1'b1;
      end
      tick();
   endtask

   task automatic run_window(input int n_sym, input int n_err, input bit err_on_clr);
      for (int i = 0; i < n_sym; i++) step(1'b1, i >= n_err, i < n_err, 1'b0);
      step(err_on_clr, 1'b0, err_on_clr, 1'b1);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      bus.sym_clk_ena       = 1'b1;
      bus.sym_error         = 1'b1;
      bus.sym_correct       = 1'b1;
      bus.clear_accumulator = 1'b1;
      repeat (3) tick();
      check("rst symbol_count", bus.symbol_count, 0);
      check("rst error_count", bus.error_count, 0);
      check("rst symbols_latched", bus.symbols_latched, 0);
      check("rst errors_latched", bus.errors_latched, 0);
      check("rst result_valid", bus.result_valid, 0);
      check("rst saturated", bus.saturated, 0);
      check("rst illegal_flag", bus.illegal_flag, 0);
      check("rst locked", bus.locked, 0);
      check("rst meas_state", bus.meas_state, 0);
      rst = 1'b0;
      bus.sym_clk_ena       = 1'b0;
      bus.sym_error         = 1'b0;
      bus.sym_correct       = 1'b0;
      bus.clear_accumulator = 1'b0;
      m_counting = 1'b0;
      m_sym      = 0;
      m_err      = 0;
      m_ill      = 1'b0;
      m_good     = 0;
      m_locked   = 1'b0;
   endtask

   // Scoreboard: every result_valid must match a closed window.
   always @(negedge clk) begin
      res_t e;
      if (bus.result_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected result_valid", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("symbols_latched", bus.symbols_latched, e.sym);
            check("errors_latched", bus.errors_latched, e.err);
            check("locked at result_valid", bus.locked, e.lck);
         end
      end
   end

   initial begin
      int exp_sym;
      int exp_err;

      vecs[0] = '{ena: 1, cor: 1, err: 0, d_sym: 1, d_err: 0, ill: 0};
      vecs[1] = '{ena: 1, cor: 0, err: 1, d_sym: 1, d_err: 1, ill: 0};
      vecs[2] = '{ena: 1, cor: 0, err: 0, d_sym: 0, d_err: 0, ill: 0};
      vecs[3] = '{ena: 0, cor: 1, err: 1, d_sym: 0, d_err: 0, ill: 0};
      vecs[4] = '{ena: 0, cor: 1, err: 0, d_sym: 0, d_err: 0, ill: 0};
      vecs[5] = '{ena: 1, cor: 1, err: 0, d_sym: 1, d_err: 0, ill: 0};
      vecs[6] = '{ena: 1, cor: 1, err: 1, d_sym: 1, d_err: 1, ill: 1};
      vecs[7] = '{ena: 1, cor: 0, err: 1, d_sym: 1, d_err: 1, ill: 1};
      vecs[8] = '{ena: 0, cor: 0, err: 0, d_sym: 0, d_err: 0, ill: 1};

      rst4 = 1'b1;
      bus4.sym_clk_ena       = 1'b0;
      bus4.sym_correct       = 1'b0;
      bus4.sym_error         = 1'b0;
      bus4.clear_accumulator = 1'b0;

      reset_dut();

      // Nothing counts before the first boundary.
      repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0);
      check("idle symbol_count", bus.symbol_count, 0);
      check("idle error_count", bus.error_count, 0);
      check("idle meas_state", bus.meas_state, 0);

      // First boundary arms counting without producing a result.
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("first clear meas_state", bus.meas_state, 1);
      check("first clear result_valid", bus.result_valid, 0);
      check("first clear symbol_count", bus.symbol_count, 0);

      // Qualification table.
      exp_sym = 0;
      exp_err = 0;
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].ena, vecs[i].cor, vecs[i].err, 1'b0);
         exp_sym += vecs[i].d_sym;
         exp_err += vecs[i].d_err;
         check($sformatf("vec%0d symbol_count", i), bus.symbol_count, exp_sym);
         check($sformatf("vec%0d error_count", i), bus.error_count, exp_err);
         check($sformatf("vec%0d illegal_flag", i), bus.illegal_flag, vecs[i].ill);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("illegal_flag cleared", bus.illegal_flag, 0);
      check("symbol_count restart", bus.symbol_count, 0);

      // 1000 symbols, 7 errors.
      run_window(1000, 7, 1'b0);
      check("result_valid high", bus.result_valid, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("result_valid one cycle", bus.result_valid, 0);

      // Partial window discarded by reset; counting needs a new boundary.
      repeat (20) step(1'b1, 1'b0, 1'b1, 1'b0);
      reset_dut();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("post-reset idle symbol_count", bus.symbol_count, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Lock acquisition, loss on 101 errors, re-acquisition.
      run_window(1000, 0, 1'b0);
      check("locked after 1 good", bus.locked, 0);
      run_window(1000, 0, 1'b0);
      check("locked after 2 good", bus.locked, 1);
      run_window(1000, 0, 1'b0);
      run_window(1000, 101, 1'b0);
      check("locked after 101 errors", bus.locked, 0);
      run_window(1000, 0, 1'b0);
      run_window(1000, 0, 1'b0);
      check("relocked", bus.locked, 1);
      run_window(200, 100, 1'b0);
      check("locked at threshold", bus.locked, 1);

      // Error on the boundary cycle belongs to the closing window.
      run_window(10, 2, 1'b1);
      check("boundary new error_count", bus.error_count, 0);
      check("boundary new symbol_count", bus.symbol_count, 0);

      // Empty window still latches and counts as good.
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // A single illegal symbol makes the window bad.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("locked after illegal", bus.locked, 0);

      // Narrow counters: saturation, per-window clear, reset mid-window.
      tick();
      rst4 = 1'b0;
      bus4.clear_accumulator = 1'b1;
      tick();
      bus4.clear_accumulator = 1'b0;
      bus4.sym_clk_ena       = 1'b1;
      bus4.sym_error         = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) check("sat4 before all-ones", bus4.saturated, 0);
         if (i == 15) check("sat4 at all-ones", bus4.saturated, 1);
      end
      check("sat4 error_count", bus4.error_count, 15);
      check("sat4 symbol_count", bus4.symbol_count, 15);
      check("sat4 saturated", bus4.saturated, 1);
      bus4.sym_clk_ena       = 1'b0;
      bus4.clear_accumulator = 1'b1;
      tick();
      bus4.clear_accumulator = 1'b0;
      check("sat4 result_valid", bus4.result_valid, 1);
      check("sat4 errors_latched", bus4.errors_latched, 15);
      check("sat4 saturated cleared", bus4.saturated, 0);
      check("sat4 locked", bus4.locked, 0);
      bus4.sym_clk_ena = 1'b1;
      repeat (3) tick();
      check("sat4 counting again", bus4.error_count, 3);
      rst4 = 1'b1;
      tick();
      check("rst4 error_count", bus4.error_count, 0);
      check("rst4 symbol_count", bus4.symbol_count, 0);
      check("rst4 errors_latched", bus4.errors_latched, 0);
      check("rst4 meas_state", bus4.meas_state, 0);
      tick();
      check("rst4 result_valid", bus4.result_valid, 0);

      tick();
      check("scoreboard drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
